// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter (SLL/SRL/SRA/ROL by 0-15) with a start/busy/done handshake.
// Define SHIFT_SEQ_BYTE_STEP_EN to enable the coarse shift-by-8 step; otherwise every shift uses single-bit steps.
module shift_sequencer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [15:0] A,
  input  logic [3:0]  Amt,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Result
);

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BYTE = 2'b01,
    BIT  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t      state;
  op_t         op_q;
  logic [15:0] w;
  logic [3:0]  c;
  logic [15:0] w_bit;

  function automatic logic [15:0] bit_shift(input op_t op, input logic [15:0] v);
    logic [15:0] r;
    case (op)
      SLL:     r = {v[14:0], 1'b0};
      SRL:     r = {1'b0, v[15:1]};
      SRA:     r = {v[15], v[15:1]};
      default: r = {v[14:0], v[15]};
    endcase
    return r;
  endfunction

  assign w_bit = bit_shift(op_q, w);

`ifdef SHIFT_SEQ_BYTE_STEP_EN
  logic [15:0] w_byte;

  // Same byte move as the immediate upper-byte load, widened with the op's fill rule.
  function automatic logic [15:0] byte_shift(input op_t op, input logic [15:0] v);
    logic [15:0] r;
    case (op)
      SLL:     r = {v[7:0], 8'h00};
      SRL:     r = {8'h00, v[15:8]};
      SRA:     r = {{8{v[15]}}, v[15:8]};
      default: r = {v[7:0], v[15:8]};
    endcase
    return r;
  endfunction

  assign w_byte = byte_shift(op_q, w);
`endif

  // NOTE: every register here is state, so all assignments are non-blocking; blocking
  // assignments in a clocked block make results depend on statement order and sim races.
  always_ff @(posedge CLK) begin
    // NOTE: reset clears the full datapath too, so no stale operand survives an abandoned shift.
    if (Reset) begin
      state  <= IDLE;
      op_q   <= SLL;
      w      <= 16'h0000;
      c      <= 4'd0;
      Result <= 16'h0000;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (Start) begin
            w    <= A;
            op_q <= op_t'(Op);
            c    <= Amt;
            if (Amt == 4'd0) begin
              Result <= A;
              Done   <= 1'b1;
              state  <= DONE;
`ifdef SHIFT_SEQ_BYTE_STEP_EN
            end else if (Amt[3]) begin
              Busy  <= 1'b1;
              state <= BYTE;
`endif
            end else begin
              Busy  <= 1'b1;
              state <= BIT;
            end
          end
        end

`ifdef SHIFT_SEQ_BYTE_STEP_EN
        BYTE: begin
          w <= w_byte;
          c <= c - 4'd8;
          if (c[2:0] == 3'd0) begin
            Result <= w_byte;
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= DONE;
          end else begin
            state <= BIT;
          end
        end
`endif

        BIT: begin
          w <= w_bit;
          c <= c - 4'd1;
          if (c == 4'd1) begin
            Result <= w_bit;
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= DONE;
          end
        end

        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed operations with literal results and
// latencies, plus a cycle-by-cycle comparison against an arithmetic reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  shift_sequencer dut (
    .CLK    (clk),
    .Reset  (reset),
    .Start  (start),
    .Op     (op),
    .A      (a),
    .Amt    (amt),
    .Busy   (busy),
    .Done   (done),
    .Result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result from plain shift arithmetic, latency from the step-count formula.
  function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [15:0] v,
                                            input logic [3:0] n);
    logic [31:0] x;
    case (o)
      2'b00:   return v << n;
      2'b01:   return v >> n;
      2'b10:   return 16'($signed(v) >>> n);
      default: begin
        x = {v, v} << n;
        return x[31:16];
      end
    endcase
  endfunction

  function automatic int ref_steps(input logic [3:0] n);
`ifdef SHIFT_SEQ_BYTE_STEP_EN
    return ((n >= 8) ? 1 : 0) + (n % 8);
`else
    return n;
`endif
  endfunction

  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_result = 16'h0000;
  logic [15:0] m_pending = 16'h0000;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid  = 1'b1;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_result = 16'h0000;
      m_left   = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_result = m_pending;
        end
      end else if (start) begin
        m_pending = ref_shift(op, a, amt);
        m_left    = ref_steps(amt);
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = m_pending;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_result", result, m_result);
    end
  end

  // Issues one operation and waits for Done; noise>0 re-asserts Start with other operands
  // for that many busy cycles to confirm it is ignored.
  task automatic do_op(input string name, input logic [1:0] o, input logic [15:0] v,
                       input logic [3:0] n, input logic [15:0] exp_res, input int exp_k,
                       input bit sync, input int noise);
    int rel;
    int busy_cnt;
    if (sync) repeat (2) @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = v;
    amt   = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'h5A5A;
    amt   = 4'd3;
    rel      = 0;
    busy_cnt = 0;
    for (int j = 1; j <= 40; j++) begin
      if (done) begin
        rel = j;
        break;
      end
      busy_cnt += int'(busy);
      if (j <= noise) begin
        start = 1'b1;
        a     = 16'h0001;
        amt   = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (rel == 0) begin
      check({name, "_done_timeout"}, 0, 1);
    end else begin
      check({name, "_latency"}, rel, exp_k);
      check({name, "_result"}, result, exp_res);
      check({name, "_busy_cycles"}, busy_cnt, exp_k - 1);
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      pulses += int'(done);
    end
  endtask

`ifdef SHIFT_SEQ_BYTE_STEP_EN
  localparam int K8  = 2;
  localparam int K9  = 3;
  localparam int K12 = 6;
  localparam int K15 = 9;
`else
  localparam int K8  = 9;
  localparam int K9  = 10;
  localparam int K12 = 13;
  localparam int K15 = 16;
`endif

  initial begin
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 16'h0000;
    amt   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    reset = 1'b0;

    do_op("sll_8",   2'b00, 16'h00AB, 4'd8,  16'hAB00, K8,  1'b1, 0);
    do_op("sra_15",  2'b10, 16'h8001, 4'd15, 16'hFFFF, K15, 1'b1, 0);
    do_op("rol_4",   2'b11, 16'h1234, 4'd4,  16'h2341, 5,   1'b1, 0);
    do_op("srl_0_b2b", 2'b01, 16'hBEEF, 4'd0, 16'hBEEF, 1,  1'b0, 0);

    do_op("srl_12_ignore", 2'b01, 16'hF000, 4'd12, 16'h000F, K12, 1'b1, 2);
    count_done(20, pulses);
    check("srl_12_single_done", pulses, 0);

    do_op("rol_8",   2'b11, 16'h1234, 4'd8,  16'h3412, K8,  1'b1, 0);
    do_op("sra_7",   2'b10, 16'h8000, 4'd7,  16'hFF00, 8,   1'b1, 0);
    do_op("sll_15",  2'b00, 16'h0001, 4'd15, 16'h8000, K15, 1'b1, 0);
    do_op("rol_15",  2'b11, 16'h8001, 4'd15, 16'hC000, K15, 1'b1, 0);
    do_op("srl_9",   2'b01, 16'h8421, 4'd9,  16'h0042, K9,  1'b1, 0);

    // Abort a shift mid-flight: reset sampled at edge N+2.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 16'hFFFF;
    amt   = 4'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_result", result, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    reset = 1'b0;
    count_done(20, pulses);
    check("abort_no_done", pulses, 0);
    do_op("sll_1_after_abort", 2'b00, 16'h0001, 4'd1, 16'h0002, 2, 1'b1, 0);

    repeat (3) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
